alu_exec_stage: RTL



---
 rtl/alu_exec_stage_if.sv | 24 ++
 rtl/alu_exec_stage.sv | 124 ++++++++++++
 2 files changed

// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - operand/op request and result handshake bundle for alu_exec_stage
interface alu_exec_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [2:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;

  modport master (
    output in_valid, SrcA, SrcB, ALUControl, out_ready,
    input  in_ready, out_valid, ALUResult, Zero
  );

  modport slave (
    input  in_valid, SrcA, SrcB, ALUControl, out_ready,
    output in_ready, out_valid, ALUResult, Zero
  );
endinterface

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU execute stage with registered result; ALU_ITER_SHIFT_EN enables the iterative SLL/SRL shifter
// Without ALU_ITER_SHIFT_EN, shift codes return 0 in one cycle and busy_o is tied low.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_exec_stage_if.slave   bus,
  output logic              busy_o
);
  logic [WIDTH-1:0] a, b, diff, res_d;
  logic             slt;
  logic             accept;
  logic             out_valid_q, zero_q;
  logic [WIDTH-1:0] res_q;

  assign a    = bus.SrcA;
  assign b    = bus.SrcB;
  assign diff = a - b;
  // Signed less-than from the subtractor: sign of difference corrected by overflow.
  assign slt  = diff[WIDTH-1] ^ ((a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff[WIDTH-1]));

  always_comb begin
    res_d = '0;
    case (bus.ALUControl)
      3'b000:  res_d = a + b;
      3'b001:  res_d = diff;
      3'b010:  res_d = a & b;
      3'b011:  res_d = a | b;
      3'b100:  res_d = a ^ b;
      3'b101:  res_d = {{(WIDTH-1){1'b0}}, slt};
`ifdef ALU_ITER_SHIFT_EN
      // Only reached for a zero shift amount; longer shifts go through SHIFT.
      default: res_d = a;
`else
      default: res_d = '0;
`endif
    endcase
  end

  assign bus.out_valid = out_valid_q;
  assign bus.ALUResult = res_q;
  assign bus.Zero      = zero_q;
  assign accept        = bus.in_valid & bus.in_ready;

`ifdef ALU_ITER_SHIFT_EN
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, shamt;
  logic             dir_q;
  logic             start_shift;

  assign shamt        = b[SHW-1:0];
  assign start_shift  = (bus.ALUControl[2:1] == 2'b11) && (shamt != '0);
  assign acc_d        = dir_q ? {1'b0, acc_q[WIDTH-1:1]} : {acc_q[WIDTH-2:0], 1'b0};
  assign bus.in_ready = (state_q == IDLE) & (~out_valid_q | bus.out_ready);
  assign busy_o       = (state_q == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready)
        out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (start_shift) begin
              acc_q   <= a;
              cnt_q   <= shamt;
              dir_q   <= bus.ALUControl[0];
              state_q <= SHIFT;
            end else begin
              res_q       <= res_d;
              zero_q      <= (res_d == '0);
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - SHW'(1);
          // Output register is guaranteed empty here because in_ready gated the start.
          if (cnt_q == SHW'(1)) begin
            res_q       <= acc_d;
            zero_q      <= (acc_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign busy_o       = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready)
        out_valid_q <= 1'b0;
      if (accept) begin
        res_q       <= res_d;
        zero_q      <= (res_d == '0);
        out_valid_q <= 1'b1;
      end
    end
  end
`endif
endmodule
